fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of one FIFO_internal instance between NUM_REQ producers.
- Each producer uses a valid/ready handshake.
- The arbiter grants one producer at a time for a burst of up to BURST_LEN words, then rotates the grant.
- It drives the FIFO write enable and data, and stalls on the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- WORD_LENGTH, 8, data word width; must match the FIFO.
- BURST_LEN, 4, max consecutive words accepted per grant (>=1).
- CNT_WIDTH, $clog2(BURST_LEN)+1, burst counter width (derived, do not override).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous active-high reset.
- i_req_valid  in  NUM_REQ  per-producer data valid.
- i_req_data  in  NUM_REQ*WORD_LENGTH  producer n data in bits [n*WORD_LENGTH +: WORD_LENGTH].
- o_req_ready  out  NUM_REQ  per-producer ready; a word transfers when valid&ready.
- i_fifo_full  in  1  from FIFO o_full.
- o_fifo_write_en  out  1  to FIFO i_write_en.
- o_fifo_data  out  WORD_LENGTH  to FIFO i_data_in.
- o_grant  out  NUM_REQ  one-hot current grant, all-zero when idle.
- o_busy  out  1  high while in GRANT.

Behaviour:
- Reset (async, active-high): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
  - Outputs during and after reset until the first grant: o_grant=0, o_busy=0, o_req_ready=0, o_fifo_write_en=0, o_fifo_data=0.
  - Reset mid-burst aborts the burst immediately. No write is issued in the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any i_req_valid bit is set, choose the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the one-hot grant, clear burst_cnt, go to GRANT.
  - Arbitration latency: 1 cycle from valid to grant. No transfer occurs in IDLE.
- GRANT, granted index g:
  - o_req_ready[g] = ~i_fifo_full; all other ready bits are 0.
  - o_fifo_write_en = i_req_valid[g] & ~i_fifo_full. All outputs here are combinational from registered grant and inputs.
  - o_fifo_data = i_req_data[g]. It is 0 when no grant.
  - On a transfer, burst_cnt increments.
- Release GRANT to IDLE (rr_ptr <= (g+1) mod NUM_REQ) when either:
  - (a) a transfer occurs with burst_cnt==BURST_LEN-1, i.e. BURST_LEN words done; or
  - (b) i_req_valid[g]==0 in a GRANT cycle. The producer withdrew; this counts as no transfer.
- FIFO full while granted: no transfer, burst_cnt holds, grant holds (no release on full). Writes resume the cycle full deasserts.
- Simultaneous valid=1 and full=1 on the last burst word: not a transfer, so no release.
- Rotation: one idle bubble cycle between consecutive grants.
  - Worst-case wait for a continuously valid producer: (NUM_REQ-1)*(BURST_LEN+1) cycles.
- o_busy = (state==GRANT).
- Invariant: o_grant is zero or one-hot. o_fifo_write_en is never asserted while i_fifo_full=1.

Optional Feature:
- Macro FIFO_ARB_PRIORITY0_EN.
- Defined:
  - Producer 0 is high priority. In IDLE, if i_req_valid[0]=1 it wins regardless of rr_ptr.
  - Its burst is unlimited: release only on withdraw, rule (b). rr_ptr is not updated after a producer-0 grant.
  - Other producers follow round-robin as normal.
- Undefined: all producers are equal, pure round-robin as above.

Test Plan:
- Reset then single producer 1 holding valid with 6 words, FIFO not full, BURST_LEN=4 -> grant=0010 one cycle after valid; words 0..3 written on 4 consecutive cycles; 1 IDLE cycle; 2nd grant to producer 1; words 4..5 written.
- Producers 0,2,3 all valid continuously -> grant order 0,2,3,0... each for 4 writes, o_fifo_data matches the granted producer's stream, 1 bubble between grants.
- Producer 2 granted, i_fifo_full=1 for 3 cycles after its 2nd word -> write_en=0 and ready[2]=0 for those 3 cycles; grant held; remaining 2 words written after full drops; then release.
- Producer 3 granted, valid drops after 1 word -> next cycle IDLE, rr_ptr=0, only 1 write issued.
- Assert i_reset asynchronously mid-burst (between clock edges) -> o_grant, o_busy, o_fifo_write_en go 0 immediately; after release, arbitration restarts from producer 0.
- With FIFO_ARB_PRIORITY0_EN, producers 0 and 1 valid, producer 0 sends 10 words -> 10 consecutive writes from producer 0 with no rotation; producer 1 is granted only after producer 0 valid drops.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional macro FIFO_ARB_PRIORITY0_EN: producer 0 is high priority with unlimited bursts.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int BURST_LEN   = 4,
    parameter int CNT_WIDTH   = $clog2(BURST_LEN) + 1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic                           i_fifo_full,
    output logic                           o_fifo_write_en,
    output logic [WORD_LENGTH-1:0]         o_fifo_data,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     next_ptr;
    logic                 is_prio;
    logic                 xfer;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NUM_REQ;
            if (!pick_found && i_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
`ifdef FIFO_ARB_PRIORITY0_EN
        if (i_req_valid[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        gidx_d          = gidx_q;
        rr_ptr_d        = rr_ptr_q;
        burst_cnt_d     = burst_cnt_q;
        o_req_ready     = '0;
        o_fifo_write_en = 1'b0;
        o_fifo_data     = '0;
        o_busy          = 1'b0;
        xfer            = 1'b0;
`ifdef FIFO_ARB_PRIORITY0_EN
        is_prio         = (gidx_q == '0);
`else
        is_prio         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    gidx_d      = pick_idx;
                    burst_cnt_d = '0;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                o_busy              = 1'b1;
                o_req_ready[gidx_q] = ~i_fifo_full;
                xfer                = i_req_valid[gidx_q] & ~i_fifo_full;
                o_fifo_write_en     = xfer;
                o_fifo_data         = i_req_data[gidx_q*WORD_LENGTH +: WORD_LENGTH];
                // Withdraw, or the last burst word actually transferring, ends the grant.
                if (!i_req_valid[gidx_q] ||
                    (xfer && !is_prio && burst_cnt_q == CNT_WIDTH'(BURST_LEN - 1))) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    if (!is_prio) rr_ptr_d = next_ptr;
                end else if (xfer && !is_prio) begin
                    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign o_grant = grant_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, WORD_LENGTH=8, BURST_LEN=4).
module tb_fifo_write_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        i_fifo_full;
    logic        o_fifo_write_en;
    logic [7:0]  o_fifo_data;
    logic [3:0]  o_grant;
    logic        o_busy;

    int    checks;
    int    errors;
    int    wc[4];
    string phase;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .WORD_LENGTH(8),
        .BURST_LEN  (4)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .i_req_data     (i_req_data),
        .o_req_ready    (o_req_ready),
        .i_fifo_full    (i_fifo_full),
        .o_fifo_write_en(o_fifo_write_en),
        .o_fifo_data    (o_fifo_data),
        .o_grant        (o_grant),
        .o_busy         (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // Producer n presents word n*16 + (words it has already transferred).
    task automatic drive_data();
        for (int n = 0; n < 4; n++) i_req_data[n*8 +: 8] = 8'(n*16 + wc[n]);
    endtask

    task automatic clear_words();
        for (int n = 0; n < 4; n++) wc[n] = 0;
        drive_data();
    endtask

    task automatic chk_idle_outputs();
        chk("grant", 32'(o_grant), 32'h0);
        chk("busy", 32'(o_busy), 32'h0);
        chk("ready", 32'(o_req_ready), 32'h0);
        chk("we", 32'(o_fifo_write_en), 32'h0);
        chk("data", 32'(o_fifo_data), 32'h0);
    endtask

    // One clock cycle: check outputs against the expected grant / write, then clock it.
    task automatic cyc(input logic [3:0] eg, input logic ew);
        int         idx;
        logic [7:0] ed;
        logic [3:0] er;
        idx = 0;
        for (int n = 0; n < 4; n++) if (eg[n]) idx = n;
        #1;
        ed = (eg == 4'b0) ? 8'h00 : 8'(idx*16 + wc[idx]);
        er = (eg != 4'b0 && !i_fifo_full) ? eg : 4'b0;
        chk("grant", 32'(o_grant), 32'(eg));
        chk("busy", 32'(o_busy), 32'(eg != 4'b0));
        chk("ready", 32'(o_req_ready), 32'(er));
        chk("we", 32'(o_fifo_write_en), 32'(ew));
        chk("data", 32'(o_fifo_data), 32'(ed));
        @(posedge i_clk);
        #1;
        if (ew) wc[idx]++;
        drive_data();
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        #2;
        i_reset = 1'b0;
        clear_words();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        phase       = "reset";
        i_reset     = 1'b1;
        i_req_valid = 4'b0;
        i_fifo_full = 1'b0;
        clear_words();
        #2;
        chk_idle_outputs();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        chk_idle_outputs();

`ifdef FIFO_ARB_PRIORITY0_EN
        phase = "prio0";
        i_req_valid = 4'b0011;
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 10; k++) cyc(4'b0001, 1'b1);
        i_req_valid = 4'b0010;
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0010, 1'b1);
        chk("p1_words", 32'(wc[1]), 32'd1);
        chk("p0_words", 32'(wc[0]), 32'd10);
`else
        phase = "single_p1";
        i_req_valid = 4'b0010;
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b0010, 1'b1);
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 2; k++) cyc(4'b0010, 1'b1);
        i_req_valid = 4'b0000;
        cyc(4'b0010, 1'b0);
        cyc(4'b0000, 1'b0);

        phase = "rr_0_2_3";
        pulse_reset();
        i_req_valid = 4'b1101;
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b0001, 1'b1);
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b1);
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b1000, 1'b1);
        cyc(4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) cyc(4'b0001, 1'b1);
        i_req_valid = 4'b0000;
        cyc(4'b0000, 1'b0);

        phase = "full_stall";
        i_req_valid = 4'b0100;
        cyc(4'b0000, 1'b0);
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        i_fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) cyc(4'b0100, 1'b0);
        i_fifo_full = 1'b0;
        cyc(4'b0100, 1'b1);
        cyc(4'b0100, 1'b1);
        i_req_valid = 4'b0000;
        cyc(4'b0000, 1'b0);

        phase = "withdraw_p3";
        i_req_valid = 4'b1000;
        cyc(4'b0000, 1'b0);
        cyc(4'b1000, 1'b1);
        i_req_valid = 4'b0000;
        cyc(4'b1000, 1'b0);
        // rr_ptr must now be 0: with 0 and 3 valid, 0 wins.
        i_req_valid = 4'b1001;
        cyc(4'b0000, 1'b0);

        phase = "full_last_word";
        cyc(4'b0001, 1'b1);
        cyc(4'b0001, 1'b1);
        cyc(4'b0001, 1'b1);
        i_fifo_full = 1'b1;
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b0);
        i_fifo_full = 1'b0;
        cyc(4'b0001, 1'b1);
        i_req_valid = 4'b0000;
        cyc(4'b0000, 1'b0);

        phase = "async_reset";
        i_req_valid = 4'b0100;
        cyc(4'b0000, 1'b0);
        cyc(4'b0100, 1'b1);
        #2;
        i_reset = 1'b1;
        i_req_valid = 4'b0101;
        #1;
        chk_idle_outputs();
        #1;
        i_reset = 1'b0;
        clear_words();
        @(posedge i_clk);
        #1;
        cyc(4'b0001, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
